// File: rtl/outfea_wr_addrgen.sv
// Output-feature write address generator.
// Turns the stream of finished output pixels (x innermost, then y, then map)
// into a registered write enable, address and data for the output feature
// map memory. Address = map*OUT_W*OUT_H + y*OUT_W + x.
module outfea_wr_addrgen #(
  parameter int OUT_W      = 8,
  parameter int OUT_H      = 8,
  parameter int NUM_MAPS   = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int X_WIDTH    = 3,
  parameter int Y_WIDTH    = 3,
  parameter int M_WIDTH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Address strides held at the address width so the sum never truncates
  // for legal parameter sets.
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(OUT_W);
  localparam logic [ADDR_WIDTH-1:0] MAP_STRIDE = ADDR_WIDTH'(OUT_W * OUT_H);

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(OUT_W - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(OUT_H - 1);
  localparam logic [M_WIDTH-1:0] M_LAST = M_WIDTH'(NUM_MAPS - 1);

  state_t                  state_q, state_d;
  logic [X_WIDTH-1:0]      x_q, x_d;
  logic [Y_WIDTH-1:0]      y_q, y_d;
  logic [M_WIDTH-1:0]      m_q, m_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    err_q, err_d;

  logic                    last_x, last_y, last_m;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  assign last_x   = (x_q == X_LAST);
  assign last_y   = (y_q == Y_LAST);
  assign last_m   = (m_q == M_LAST);
  assign cur_addr = ADDR_WIDTH'(m_q) * MAP_STRIDE
                  + ADDR_WIDTH'(y_q) * ROW_STRIDE
                  + ADDR_WIDTH'(x_q);

  // Next-state logic: start wins over everything, then accept/err handling.
  always_comb begin
    // NOTE: every target gets a default first (hold or clear) so no path
    // through the branches below leaves a signal unassigned and infers a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    m_d       = m_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    if (start) begin
      state_d = S_RUN;
      x_d     = '0;
      y_d     = '0;
      m_d     = '0;
      err_d   = 1'b0;
    end else if (in_valid) begin
      if (state_q == S_RUN) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cur_addr;
        wr_data_d = in_data;
        if (!last_x) begin
          x_d = x_q + X_WIDTH'(1);
        end else begin
          x_d = '0;
          if (!last_y) begin
            y_d = y_q + Y_WIDTH'(1);
          end else begin
            y_d = '0;
            if (!last_m) begin
              m_d = m_q + M_WIDTH'(1);
            end else begin
              m_d     = '0;
              state_d = S_DONE;
            end
          end
        end
      end else begin
        // Pixel arrived with no frame open: drop it and flag it.
        err_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    if (reset) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      m_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      m_q       <= m_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_outfea_wr_addrgen.sv
// Scoreboard bench for outfea_wr_addrgen: a frame-level reference model pushes
// expected writes on each clock edge; a monitor on the falling edge compares.
module tb_outfea_wr_addrgen;

  localparam int OUT_W      = 8;
  localparam int OUT_H      = 8;
  localparam int NUM_MAPS   = 4;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  localparam int FRAME      = OUT_W * OUT_H * NUM_MAPS;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  in_valid = 1'b0;
  logic [DATA_WIDTH-1:0] in_data = '0;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model state, frame-level view.
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;
  int m_idx  = 0;
  int m_hold_addr = 0;
  int m_hold_data = 0;

  outfea_wr_addrgen #(
    .OUT_W(OUT_W), .OUT_H(OUT_H), .NUM_MAPS(NUM_MAPS),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .X_WIDTH(3), .Y_WIDTH(3), .M_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel index n maps to x=n%W, y=(n/W)%H, map=n/(W*H).
  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_done = 0; m_err = 0; m_idx = 0;
      m_hold_addr = 0; m_hold_data = 0;
      exp_q.delete();
    end else if (start) begin
      m_run = 1; m_done = 0; m_err = 0; m_idx = 0;
    end else if (in_valid) begin
      if (m_run) begin
        int x, y, m;
        wr_t w;
        x = m_idx % OUT_W;
        y = (m_idx / OUT_W) % OUT_H;
        m = m_idx / (OUT_W * OUT_H);
        w.addr = m * OUT_W * OUT_H + y * OUT_W + x;
        w.data = int'(in_data);
        exp_q.push_back(w);
        m_hold_addr = w.addr;
        m_hold_data = w.data;
        m_idx++;
        if (m_idx == FRAME) begin
          m_idx = 0; m_run = 0; m_done = 1;
        end
      end else begin
        m_err = 1;
      end
    end
  end

  // Monitor: every falling edge, compare outputs against the model.
  always @(negedge clk) begin
    bit exp_en;
    exp_en = (exp_q.size() != 0);
    check("wr_en", 32'(wr_en), 32'(exp_en));
    if (wr_en === 1'b1 && exp_en) begin
      wr_t w;
      w = exp_q.pop_front();
      check("wr_addr", 32'(wr_addr), 32'(w.addr));
      check("wr_data", 32'(wr_data), 32'(w.data));
    end else if (exp_en) begin
      void'(exp_q.pop_front());
    end else begin
      check("hold_addr", 32'(wr_addr), 32'(m_hold_addr));
      check("hold_data", 32'(wr_data), 32'(m_hold_data));
    end
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    check("err",  32'(err),  32'(m_err));
  end

  task automatic step(input bit s, input bit v, input logic [DATA_WIDTH-1:0] d);
    start = s; in_valid = v; in_data = d;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_pixels(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) step(0, 0, '0);
      end
      step(0, 1, DATA_WIDTH'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    do_reset();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // 1: back-to-back frame with data = index.
    step(1, 0, '0);
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < FRAME; i++) step(0, 1, DATA_WIDTH'(i));
    check("last_wr_addr", 32'(wr_addr), 32'(FRAME - 1));
    step(0, 0, '0);
    check("frame_done", 32'(done), 32'd1);
    check("frame_busy", 32'(busy), 32'd0);

    // 3: valid in DONE sets err, held until start.
    step(0, 1, 16'hdead);
    check("err_in_done", 32'(err), 32'd1);
    step(0, 0, '0);
    step(0, 0, '0);
    check("err_held", 32'(err), 32'd1);

    // 2: random gaps, full frame.
    step(1, 0, '0);
    check("err_cleared", 32'(err), 32'd0);
    run_pixels(FRAME, 1'b1);
    step(0, 0, '0);
    check("gap_frame_done", 32'(done), 32'd1);

    // 4: abort after 70 pixels, then full frame.
    step(1, 0, '0);
    run_pixels(70, 1'b0);
    step(1, 0, '0);
    run_pixels(FRAME - 1, 1'b1);
    check("abort_not_done", 32'(done), 32'd0);
    run_pixels(1, 1'b0);
    check("abort_then_done", 32'(done), 32'd1);

    // 5: start and valid together in RUN.
    step(1, 0, '0);
    run_pixels(10, 1'b0);
    step(1, 1, 16'h5a5a);
    check("start_valid_no_wr", 32'(wr_en), 32'd0);
    check("start_valid_err", 32'(err), 32'd0);
    run_pixels(1, 1'b0);
    check("restart_addr0", 32'(wr_addr), 32'd0);

    // 6: reset mid-frame with valid.
    run_pixels(20, 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_data", 32'(wr_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step(0, 1, 16'h7777);
    check("idle_valid_err", 32'(err), 32'd1);
    check("idle_valid_no_wr", 32'(wr_en), 32'd0);

    // IDLE valid after a clean reset, then a restart clears err.
    do_reset();
    step(0, 1, 16'h0001);
    check("err_in_idle", 32'(err), 32'd1);
    step(1, 0, '0);
    run_pixels(5, 1'b1);
    step(0, 0, '0);
    step(0, 0, '0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
